// File: rtl/npc_seq_ctrl.sv
// npc_seq_ctrl: multi-cycle sequencer for the NPC core.
// Steps one instruction at a time through FETCH, WAIT_IF, DECODE, MEM,
// WAIT_MEM and WB. It halts on ebreak, on an illegal instruction, or when a
// memory-wait state overstays the watchdog limit.
//
// Optional feature macro: NPC_PERF_CNT_EN adds the cycle and retired-instruction
// counters. When the macro is undefined, cyc_cnt and inst_cnt read 0 and no
// counter flops are built.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   imem_req/gnt/rvalid         instruction fetch handshake
//   dmem_req/we/gnt/rvalid      data memory handshake
//   dec_*                       decoded control bits from the control unit
//   ir_we, pc_we, rf_we         single-cycle datapath strobes
//   halt, halt_code             halted flag and reason (0 ebreak, 1 illegal, 2 timeout)
//   state                       current state encoding, for debug
//   cyc_cnt, inst_cnt           performance counters (optional feature)
module npc_seq_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic        dec_reg_wr,
  input  logic        dec_mem_rd,
  input  logic        dec_mem_wr,
  input  logic        dec_ebreak,
  input  logic        dec_illegal,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        halt,
  output logic [1:0]  halt_code,
  output logic [2:0]  state,
  output logic [63:0] cyc_cnt,
  output logic [63:0] inst_cnt
);

  localparam logic [2:0] S_FETCH    = 3'd0;
  localparam logic [2:0] S_WAIT_IF  = 3'd1;
  localparam logic [2:0] S_DECODE   = 3'd2;
  localparam logic [2:0] S_MEM      = 3'd3;
  localparam logic [2:0] S_WAIT_MEM = 3'd4;
  localparam logic [2:0] S_WB       = 3'd5;
  localparam logic [2:0] S_HALT     = 3'd6;

  localparam logic [1:0] HC_EBREAK  = 2'd0;
  localparam logic [1:0] HC_ILLEGAL = 2'd1;
  localparam logic [1:0] HC_TIMEOUT = 2'd2;

  logic [2:0]      state_nxt;
  logic [1:0]      code_nxt;
  logic [TO_W-1:0] wd_q;
  logic [TO_W-1:0] wd_inc;
  logic            timeout;
  logic            in_wait;
  logic            lat_reg_wr;
  logic            lat_mem_rd;
  logic            lat_mem_wr;

  // wd_inc counts the current cycle too, so the TIMEOUT-th cycle in a wait
  // state is the last chance for its exit condition.
  assign wd_inc  = wd_q + TO_W'(1);
  assign timeout = (wd_inc == TO_W'(TIMEOUT));
  assign in_wait = (state == S_FETCH) || (state == S_WAIT_IF) ||
                   (state == S_MEM)   || (state == S_WAIT_MEM);

  // Next-state, halt reason and strobe/request decode
  always_comb begin
    state_nxt = state;
    code_nxt  = halt_code;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_gnt)     state_nxt = S_WAIT_IF;
        else if (timeout) begin state_nxt = S_HALT; code_nxt = HC_TIMEOUT; end
      end
      S_WAIT_IF: begin
        ir_we = imem_rvalid;
        if (imem_rvalid)  state_nxt = S_DECODE;
        else if (timeout) begin state_nxt = S_HALT; code_nxt = HC_TIMEOUT; end
      end
      S_DECODE: begin
        if (dec_illegal)                   begin state_nxt = S_HALT; code_nxt = HC_ILLEGAL; end
        else if (dec_ebreak)               begin state_nxt = S_HALT; code_nxt = HC_EBREAK; end
        else if (dec_mem_rd || dec_mem_wr) state_nxt = S_MEM;
        else                               state_nxt = S_WB;
      end
      S_MEM: begin
        // Store wins when both load and store bits are latched
        dmem_req = lat_mem_rd | lat_mem_wr;
        dmem_we  = lat_mem_wr;
        if (dmem_gnt)     state_nxt = S_WAIT_MEM;
        else if (timeout) begin state_nxt = S_HALT; code_nxt = HC_TIMEOUT; end
      end
      S_WAIT_MEM: begin
        if (dmem_rvalid)  state_nxt = S_WB;
        else if (timeout) begin state_nxt = S_HALT; code_nxt = HC_TIMEOUT; end
      end
      S_WB: begin
        pc_we     = 1'b1;
        rf_we     = lat_reg_wr;
        state_nxt = S_FETCH;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      rf_we    = 1'b0;
    end
  end

  // State, halt status, watchdog and latched decode bits
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      halt       <= 1'b0;
      halt_code  <= 2'd0;
      wd_q       <= '0;
      lat_reg_wr <= 1'b0;
      lat_mem_rd <= 1'b0;
      lat_mem_wr <= 1'b0;
    end else begin
      state     <= state_nxt;
      halt      <= (state_nxt == S_HALT);
      halt_code <= code_nxt;
      if ((state_nxt != state) || !in_wait) wd_q <= '0;
      else                                  wd_q <= wd_inc;
      if (state == S_DECODE) begin
        lat_reg_wr <= dec_reg_wr;
        lat_mem_rd <= dec_mem_rd;
        lat_mem_wr <= dec_mem_wr;
      end
    end
  end

`ifdef NPC_PERF_CNT_EN
  logic [63:0] cyc_q;
  logic [63:0] inst_q;

  // Active cycles and retired instructions, both wrap modulo 2^64
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q  <= '0;
      inst_q <= '0;
    end else begin
      if (state != S_HALT) cyc_q  <= cyc_q + 64'd1;
      if (state == S_WB)   inst_q <= inst_q + 64'd1;
    end
  end

  assign cyc_cnt  = cyc_q;
  assign inst_cnt = inst_q;
`else
  assign cyc_cnt  = '0;
  assign inst_cnt = '0;
`endif

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Directed bench for npc_seq_ctrl, built with TIMEOUT=4 so the watchdog
// boundary is reachable in a few cycles.
module tb_npc_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic        dmem_req, dmem_we, dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic        dec_reg_wr = 1'b0, dec_mem_rd = 1'b0, dec_mem_wr = 1'b0;
  logic        dec_ebreak = 1'b0, dec_illegal = 1'b0;
  logic        ir_we, pc_we, rf_we, halt;
  logic [1:0]  halt_code;
  logic [2:0]  state;
  logic [63:0] cyc_cnt, inst_cnt;

  int n_pass  = 0;
  int n_total = 0;

  npc_seq_ctrl #(.TIMEOUT(4), .TO_W(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dec_reg_wr(dec_reg_wr), .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr),
    .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
    .halt(halt), .halt_code(halt_code), .state(state),
    .cyc_cnt(cyc_cnt), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic all_halt;

    // Reset: state/halt cleared, requests forced low while rst is high
    tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_halt", 64'(halt), 64'd0);
    chk("rst_code", 64'(halt_code), 64'd0);
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_pc_we", 64'(pc_we), 64'd0);
    rst = 1'b0; #1;
    chk("rel_imem_req", 64'(imem_req), 64'd1);

    // ALU op, zero-latency memory: 0,1,2,5,0 with ir_we at cycle 2, pc/rf_we at cycle 4
    imem_gnt = 1'b1; #1;
    chk("alu_c1_state", 64'(state), 64'd0);
    chk("alu_c1_ir_we", 64'(ir_we), 64'd0);
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; #1;
    chk("alu_c2_state", 64'(state), 64'd1);
    chk("alu_c2_ir_we", 64'(ir_we), 64'd1);
    tick(); imem_rvalid = 1'b0; dec_reg_wr = 1'b1; #1;
    chk("alu_c3_state", 64'(state), 64'd2);
    chk("alu_c3_ir_we", 64'(ir_we), 64'd0);
    chk("alu_c3_pc_we", 64'(pc_we), 64'd0);
    tick(); dec_reg_wr = 1'b0; #1;
    chk("alu_c4_state", 64'(state), 64'd5);
    chk("alu_c4_pc_we", 64'(pc_we), 64'd1);
    chk("alu_c4_rf_we", 64'(rf_we), 64'd1);
    tick();
    chk("alu_c5_state", 64'(state), 64'd0);
    chk("alu_c5_pc_we", 64'(pc_we), 64'd0);
    chk("alu_c5_rf_we", 64'(rf_we), 64'd0);
`ifdef NPC_PERF_CNT_EN
    chk("alu_inst_cnt", inst_cnt, 64'd1);
    chk("alu_cyc_cnt", cyc_cnt, 64'd4);
`else
    chk("alu_inst_cnt", inst_cnt, 64'd0);
    chk("alu_cyc_cnt", cyc_cnt, 64'd0);
`endif

    // Load: imem_gnt on the 4th FETCH cycle (watchdog boundary, exit wins), rvalid after 2 WAIT_MEM cycles
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ld_stall_state", 64'(state), 64'd0);
      chk("ld_stall_imem_req", 64'(imem_req), 64'd1);
      tick();
    end
    imem_gnt = 1'b1; #1;
    chk("ld_f4_state", 64'(state), 64'd0);
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; #1;
    chk("ld_wif_state", 64'(state), 64'd1);
    tick(); imem_rvalid = 1'b0; dec_mem_rd = 1'b1; dec_reg_wr = 1'b1; #1;
    chk("ld_dec_state", 64'(state), 64'd2);
    tick(); dec_mem_rd = 1'b0; dec_reg_wr = 1'b0; dmem_gnt = 1'b1; #1;
    chk("ld_mem_state", 64'(state), 64'd3);
    chk("ld_mem_req", 64'(dmem_req), 64'd1);
    chk("ld_mem_we", 64'(dmem_we), 64'd0);
    chk("ld_mem_rf_we", 64'(rf_we), 64'd0);
    tick(); dmem_gnt = 1'b0; #1;
    chk("ld_wm1_state", 64'(state), 64'd4);
    chk("ld_wm1_req", 64'(dmem_req), 64'd0);
    tick(); dmem_rvalid = 1'b1; #1;
    chk("ld_wm2_state", 64'(state), 64'd4);
    chk("ld_wm2_rf_we", 64'(rf_we), 64'd0);
    tick(); dmem_rvalid = 1'b0; #1;
    chk("ld_wb_state", 64'(state), 64'd5);
    chk("ld_wb_rf_we", 64'(rf_we), 64'd1);
    chk("ld_wb_pc_we", 64'(pc_we), 64'd1);
    tick();
    chk("ld_end_state", 64'(state), 64'd0);
    chk("ld_end_rf_we", 64'(rf_we), 64'd0);
`ifdef NPC_PERF_CNT_EN
    chk("ld_inst_cnt", inst_cnt, 64'd2);
`endif

    // Store with both rd/wr bits set (store wins), dmem_gnt one cycle late
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1;
    tick(); imem_rvalid = 1'b0; dec_mem_wr = 1'b1; dec_mem_rd = 1'b1; dec_reg_wr = 1'b0; #1;
    chk("st_dec_state", 64'(state), 64'd2);
    tick(); dec_mem_wr = 1'b0; dec_mem_rd = 1'b0; #1;
    chk("st_m1_state", 64'(state), 64'd3);
    chk("st_m1_req", 64'(dmem_req), 64'd1);
    chk("st_m1_we", 64'(dmem_we), 64'd1);
    tick(); dmem_gnt = 1'b1; #1;
    chk("st_m2_state", 64'(state), 64'd3);
    chk("st_m2_we", 64'(dmem_we), 64'd1);
    tick(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; #1;
    chk("st_wm_state", 64'(state), 64'd4);
    chk("st_wm_we", 64'(dmem_we), 64'd0);
    tick(); dmem_rvalid = 1'b0; #1;
    chk("st_wb_state", 64'(state), 64'd5);
    chk("st_wb_pc_we", 64'(pc_we), 64'd1);
    chk("st_wb_rf_we", 64'(rf_we), 64'd0);
    tick();

    // ebreak: HALT code 0, no pc_we, halt sticky for 100 cycles, rst recovers
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1;
    tick(); imem_rvalid = 1'b0; dec_ebreak = 1'b1; #1;
    chk("eb_dec_halt", 64'(halt), 64'd0);
    tick(); dec_ebreak = 1'b0; #1;
    chk("eb_state", 64'(state), 64'd6);
    chk("eb_halt", 64'(halt), 64'd1);
    chk("eb_code", 64'(halt_code), 64'd0);
    chk("eb_pc_we", 64'(pc_we), 64'd0);
    chk("eb_imem_req", 64'(imem_req), 64'd0);
    all_halt = 1'b1;
    imem_gnt = 1'b1; imem_rvalid = 1'b1; dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!(halt === 1'b1 && state === 3'd6 && pc_we === 1'b0 && imem_req === 1'b0)) all_halt = 1'b0;
    end
    chk("eb_sticky_100", 64'(all_halt), 64'd1);
    imem_gnt = 1'b0; imem_rvalid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    rst = 1'b1;
    tick();
    chk("eb_rst_state", 64'(state), 64'd0);
    chk("eb_rst_halt", 64'(halt), 64'd0);
    chk("eb_rst_imem_req", 64'(imem_req), 64'd0);
    rst = 1'b0; #1;
    chk("eb_rel_imem_req", 64'(imem_req), 64'd1);

    // Timeout: 4 FETCH cycles without gnt -> HALT code 2
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_fetch_state", 64'(state), 64'd0);
      tick();
    end
    chk("to_state", 64'(state), 64'd6);
    chk("to_halt", 64'(halt), 64'd1);
    chk("to_code", 64'(halt_code), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // rst during WAIT_MEM, then a stale rvalid in FETCH must be ignored
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1;
    tick(); imem_rvalid = 1'b0; dec_mem_rd = 1'b1; dec_reg_wr = 1'b1;
    tick(); dec_mem_rd = 1'b0; dec_reg_wr = 1'b0; dmem_gnt = 1'b1;
    tick(); dmem_gnt = 1'b0; rst = 1'b1; #1;
    chk("rw_wm_state", 64'(state), 64'd4);
    tick(); rst = 1'b0; dmem_rvalid = 1'b1; imem_rvalid = 1'b1; #1;
    chk("rw_state", 64'(state), 64'd0);
    chk("rw_rf_we", 64'(rf_we), 64'd0);
    chk("rw_pc_we", 64'(pc_we), 64'd0);
    chk("rw_ir_we", 64'(ir_we), 64'd0);
    chk("rw_code", 64'(halt_code), 64'd0);
    tick(); #1;
    chk("rw_stale_state", 64'(state), 64'd0);
    chk("rw_stale_rf_we", 64'(rf_we), 64'd0);
    dmem_rvalid = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b1;

    // illegal and ebreak together: illegal has priority -> code 1
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; #1;
    chk("il_wif_state", 64'(state), 64'd1);
    tick(); imem_rvalid = 1'b0; dec_illegal = 1'b1; dec_ebreak = 1'b1;
    tick(); dec_illegal = 1'b0; dec_ebreak = 1'b0; #1;
    chk("il_state", 64'(state), 64'd6);
    chk("il_halt", 64'(halt), 64'd1);
    chk("il_code", 64'(halt_code), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
